// File: rtl/zap_cp15_responder_pkg.sv
// ---------------------------------------------------------------------------
// zap_cp15_responder_pkg
//   Shared definitions for the CP15 responder slice:
//     - FSM state encodings (IDLE, MCR_RD, MCR_CAP, MRC_WR, BUSY)
//     - coprocessor word field bit positions
//     - the USR processor mode constant and the PC register index
//     - small decode helpers for the offered coprocessor word
// ---------------------------------------------------------------------------
package zap_cp15_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MCR_RD  = 3'd1,
      ST_MCR_CAP = 3'd2,
      ST_MRC_WR  = 3'd3,
      ST_BUSY    = 3'd4
   } cp_state_t;

   // Coprocessor word fields
   localparam int WORD_L_BIT    = 20;   // 1 = MRC (CP -> core)
   localparam int WORD_CRN_LSB  = 16;   // CRn occupies [19:16]
   localparam int WORD_CP_LSB   = 8;    // coprocessor number occupies [11:8]
   localparam int WORD_XFER_BIT = 4;    // 1 = register transfer (MCR/MRC)

   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam int         PC_INDEX = 15;

   // A word is a register transfer for us only if bit4 is set and it names our CP.
   function automatic logic is_reg_transfer(input logic [31:0] word,
                                            input logic [3:0]  cp_num);
      return word[WORD_XFER_BIT] && (word[WORD_CP_LSB +: 4] == cp_num);
   endfunction

   function automatic logic [3:0] crn_of(input logic [31:0] word);
      return word[WORD_CRN_LSB +: 4];
   endfunction

endpackage

// File: rtl/zap_cp_regbank.sv
// ---------------------------------------------------------------------------
// zap_cp_regbank
//   16x32 coprocessor register bank, one combinational read port and one
//   synchronous write port. Index 0 reads the hardwired CP_ID and silently
//   drops writes. CP register 1 is tapped out through a register as o_cp_ctrl.
//
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset (regs 1..15 -> 0)
//   i_rd_addr       read index            o_rd_data   read data (comb)
//   i_wr_en         write strobe          i_wr_addr   write index
//   i_wr_data       write data            o_cp_ctrl   CP[1], registered
// ---------------------------------------------------------------------------
module zap_cp_regbank #(
   parameter logic [31:0] CP_ID = 32'h4100_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [3:0]  i_rd_addr,
   output logic [31:0] o_rd_data,
   input  logic        i_wr_en,
   input  logic [3:0]  i_wr_addr,
   input  logic [31:0] i_wr_data,
   output logic [31:0] o_cp_ctrl
);

   // Entry 0 is never written; its read is replaced by CP_ID.
   logic [31:0] bank_r [16];

   // Read mux: index 0 returns the identification constant.
   always_comb begin
      if (i_rd_addr == 4'd0) begin
         o_rd_data = CP_ID;
      end else begin
         o_rd_data = bank_r[i_rd_addr];
      end
   end

   // Bank storage and the registered control-register tap.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 16; i++) begin
            bank_r[i] <= 32'h0;
         end
         o_cp_ctrl <= 32'h0;
      end else begin
         if (i_wr_en && (i_wr_addr != 4'd0)) begin
            bank_r[i_wr_addr] <= i_wr_data;
         end
         // Lags the bank by one cycle, so an MCR to CRn=1 shows here the
         // cycle after the bank itself is updated.
         o_cp_ctrl <= bank_r[1];
      end
   end

endmodule

// File: rtl/zap_cp15_responder.sv
// ---------------------------------------------------------------------------
// zap_cp15_responder
//   Coprocessor-side responder for the core's coprocessor interface. Accepts
//   an offered MCR/MRC word while idle, moves data between the core register
//   file and the CP register bank, then raises o_copro_done again.
//
//   Latency from acceptance to done=1: MCR 3 cycles, MRC 2, ignored word 2.
//   MRC with Rd = PC keeps o_copro_reg_en low but keeps the same timing.
//
// Optional build macro: ZAP_CP_PRIV_CHECK_EN
//   When defined, a transfer issued in USR mode updates no CP register
//   (MCR) or returns zero (MRC), and sets the sticky o_cp_priv_fault.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_copro_dav            core offers a coprocessor word
//   i_copro_word           instruction word
//   i_copro_mode           core CPSR at issue
//   i_copro_reg            physical index of Rd
//   o_copro_done           responder idle / op complete
//   o_copro_reg_en         core register write strobe
//   o_copro_reg_wr_index   core register write index
//   o_copro_reg_rd_index   core register read index
//   o_copro_reg_wr_data    core register write data
//   i_copro_reg_rd_data    core register read data (one cycle after rd_index)
//   o_cp_priv_fault        sticky USR-access fault (macro builds only)
//   o_cp_ctrl              CP register 1 for system use
// ---------------------------------------------------------------------------
module zap_cp15_responder
   import zap_cp15_responder_pkg::*;
#(
   parameter int          PHY_REGS = 64,
   parameter int          CP_NUM   = 15,
   parameter logic [31:0] CP_ID    = 32'h4100_0000
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_copro_dav,
   input  logic [31:0]                 i_copro_word,
   input  logic [31:0]                 i_copro_mode,
   input  logic [$clog2(PHY_REGS)-1:0] i_copro_reg,
   output logic                        o_copro_done,
   output logic                        o_copro_reg_en,
   output logic [$clog2(PHY_REGS)-1:0] o_copro_reg_wr_index,
   output logic [$clog2(PHY_REGS)-1:0] o_copro_reg_rd_index,
   output logic [31:0]                 o_copro_reg_wr_data,
   input  logic [31:0]                 i_copro_reg_rd_data,
`ifdef ZAP_CP_PRIV_CHECK_EN
   output logic                        o_cp_priv_fault,
`endif
   output logic [31:0]                 o_cp_ctrl
);

   localparam int IW = $clog2(PHY_REGS);

   cp_state_t   state_r;
   logic [3:0]  crn_r;          // CRn of the accepted word
   logic        usr_r;          // accepted in USR mode (always 0 without the check)
   logic        issue_usr_s;
   logic        xfer_s;
   logic        is_pc_s;
   logic [31:0] bank_rd_data_s;
   logic        bank_wr_en_s;

   assign xfer_s  = is_reg_transfer(i_copro_word, CP_NUM[3:0]);
   assign is_pc_s = (i_copro_reg == IW'(PC_INDEX));

`ifdef ZAP_CP_PRIV_CHECK_EN
   assign issue_usr_s = (i_copro_mode[4:0] == MODE_USR);
`else
   assign issue_usr_s = 1'b0;
`endif

   // The bank is only ever read while accepting an MRC; ops are serialized,
   // so reading with the offered word's CRn already sees every prior MCR.
   assign bank_wr_en_s = (state_r == ST_MCR_CAP) && !usr_r;

   zap_cp_regbank #(
      .CP_ID (CP_ID)
   ) u_regbank (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_rd_addr (crn_of(i_copro_word)),
      .o_rd_data (bank_rd_data_s),
      .i_wr_en   (bank_wr_en_s),
      .i_wr_addr (crn_r),
      .i_wr_data (i_copro_reg_rd_data),
      .o_cp_ctrl (o_cp_ctrl)
   );

   // Handshake FSM with registered interface outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r              <= ST_IDLE;
         crn_r                <= 4'd0;
         usr_r                <= 1'b0;
         o_copro_done         <= 1'b1;
         o_copro_reg_en       <= 1'b0;
         o_copro_reg_wr_index <= '0;
         o_copro_reg_rd_index <= '0;
         o_copro_reg_wr_data  <= 32'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               o_copro_reg_en <= 1'b0;
               if (i_copro_dav) begin
                  crn_r        <= crn_of(i_copro_word);
                  usr_r        <= issue_usr_s && xfer_s;
                  o_copro_done <= 1'b0;
                  if (!xfer_s) begin
                     state_r <= ST_BUSY;
                  end else if (i_copro_word[WORD_L_BIT]) begin
                     // MRC: the write strobe is visible for the single MRC_WR cycle.
                     state_r              <= ST_MRC_WR;
                     o_copro_reg_en       <= !is_pc_s;
                     o_copro_reg_wr_index <= i_copro_reg;
                     o_copro_reg_wr_data  <= issue_usr_s ? 32'h0 : bank_rd_data_s;
                  end else begin
                     state_r              <= ST_MCR_RD;
                     o_copro_reg_rd_index <= i_copro_reg;
                  end
               end else begin
                  o_copro_done <= 1'b1;
               end
            end
            ST_MCR_RD: begin
               // Core read data for rd_index arrives during MCR_CAP.
               state_r <= ST_MCR_CAP;
            end
            ST_MCR_CAP: begin
               state_r      <= ST_IDLE;
               o_copro_done <= 1'b1;
            end
            ST_MRC_WR: begin
               state_r        <= ST_IDLE;
               o_copro_reg_en <= 1'b0;
               o_copro_done   <= 1'b1;
            end
            ST_BUSY: begin
               state_r      <= ST_IDLE;
               o_copro_done <= 1'b1;
            end
            default: begin
               state_r        <= ST_IDLE;
               o_copro_reg_en <= 1'b0;
               o_copro_done   <= 1'b1;
            end
         endcase
      end
   end

`ifdef ZAP_CP_PRIV_CHECK_EN
   // Sticky fault: set by any USR-mode transfer accepted, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_cp_priv_fault <= 1'b0;
      end else if ((state_r == ST_IDLE) && i_copro_dav && xfer_s && issue_usr_s) begin
         o_cp_priv_fault <= 1'b1;
      end else begin
         o_cp_priv_fault <= o_cp_priv_fault;
      end
   end
`endif

endmodule

// File: tb/tb_zap_cp15_responder.sv
// ---------------------------------------------------------------------------
// tb_zap_cp15_responder
//   Directed and randomized MCR/MRC/ignored transactions against a reference
//   model of the CP bank and core register file held in plain arrays.
// ---------------------------------------------------------------------------
module tb_zap_cp15_responder;

   localparam int IW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          dav;
   logic [31:0]   word;
   logic [31:0]   mode;
   logic [IW-1:0] creg;
   logic          done;
   logic          reg_en;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   logic [31:0]   wr_data;
   logic [31:0]   rd_data;
   logic [31:0]   cp_ctrl;
`ifdef ZAP_CP_PRIV_CHECK_EN
   logic          priv_fault;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] core_regs [64];
   logic [31:0] cp_model  [16];
   logic        fault_exp;

   always #5 clk = ~clk;

   zap_cp15_responder #(
      .PHY_REGS (64),
      .CP_NUM   (15),
      .CP_ID    (32'h4100_0000)
   ) dut (
      .i_clk                (clk),
      .i_reset              (reset),
      .i_copro_dav          (dav),
      .i_copro_word         (word),
      .i_copro_mode         (mode),
      .i_copro_reg          (creg),
      .o_copro_done         (done),
      .o_copro_reg_en       (reg_en),
      .o_copro_reg_wr_index (wr_idx),
      .o_copro_reg_rd_index (rd_idx),
      .o_copro_reg_wr_data  (wr_data),
      .i_copro_reg_rd_data  (rd_data),
`ifdef ZAP_CP_PRIV_CHECK_EN
      .o_cp_priv_fault      (priv_fault),
`endif
      .o_cp_ctrl            (cp_ctrl)
   );

   // Core register file read port: registered, valid one cycle after index.
   always @(posedge clk) rd_data <= core_regs[rd_idx];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic l, input logic [3:0] crn,
                                      input logic [3:0] cp, input logic b4);
      logic [31:0] w;
      w        = $urandom;
      w[20]    = l;
      w[19:16] = crn;
      w[11:8]  = cp;
      w[4]     = b4;
      return w;
   endfunction

   // Offer one word, then watch each cycle until done returns (bounded).
   task automatic run_op(input logic [31:0] w, input logic [IW-1:0] r, input logic [31:0] m,
                         output int lat, output int nwr, output logic [IW-1:0] widx,
                         output logic [31:0] wdat, output logic [IW-1:0] ridx1);
      @(negedge clk);
      check("done_before_accept", {31'h0, done}, 32'h1);
      dav  = 1'b1;
      word = w;
      creg = r;
      mode = m;
      lat  = -1;
      nwr  = 0;
      widx = '0;
      wdat = 32'h0;
      ridx1 = '0;
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            dav   = 1'b0;
            ridx1 = rd_idx;
         end
         if (reg_en) begin
            nwr++;
            widx = wr_idx;
            wdat = wr_data;
         end
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   // Reference: expected latency/write behaviour computed from the op rules.
   task automatic apply(input logic [31:0] w, input logic [IW-1:0] r, input logic [31:0] m);
      int            lat, nwr, exp_lat;
      logic [IW-1:0] widx, ridx1;
      logic [31:0]   wdat, exp_data;
      logic          xfer, is_mrc, usr;
      logic [3:0]    crn;
      xfer   = w[4] && (w[11:8] == 4'd15);
      is_mrc = w[20];
      crn    = w[19:16];
      usr    = 1'b0;
`ifdef ZAP_CP_PRIV_CHECK_EN
      usr    = xfer && (m[4:0] == 5'b10000);
`endif
      run_op(w, r, m, lat, nwr, widx, wdat, ridx1);
      exp_lat = (xfer && !is_mrc) ? 3 : 2;
      check("latency", lat, exp_lat);
      if (xfer && is_mrc) begin
         exp_data = usr ? 32'h0 : cp_model[crn];
         if (r == 6'd15) begin
            check("pc_write_suppressed", nwr, 32'd0);
         end else begin
            check("write_count", nwr, 32'd1);
            check("wr_index", {26'h0, widx}, {26'h0, r});
            check("wr_data", wdat, exp_data);
            core_regs[r] = exp_data;
         end
      end else begin
         check("write_count", nwr, 32'd0);
         if (xfer) begin
            check("rd_index", {26'h0, ridx1}, {26'h0, r});
            if ((crn != 4'd0) && !usr) cp_model[crn] = core_regs[r];
         end
      end
      if (usr) fault_exp = 1'b1;
      @(negedge clk);
      check("cp_ctrl", cp_ctrl, cp_model[1]);
      check("done_idle", {31'h0, done}, 32'h1);
`ifdef ZAP_CP_PRIV_CHECK_EN
      check("priv_fault", {31'h0, priv_fault}, {31'h0, fault_exp});
`endif
   endtask

   initial begin
      reset     = 1'b1;
      dav       = 1'b0;
      word      = 32'h0;
      mode      = 32'h13;
      creg      = '0;
      fault_exp = 1'b0;
      for (int i = 0; i < 64; i++) core_regs[i] = $urandom;
      cp_model[0] = 32'h4100_0000;
      for (int i = 1; i < 16; i++) cp_model[i] = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_done", {31'h0, done}, 32'h1);
      check("rst_reg_en", {31'h0, reg_en}, 32'h0);
      check("rst_wr_index", {26'h0, wr_idx}, 32'h0);
      check("rst_rd_index", {26'h0, rd_idx}, 32'h0);
      check("rst_wr_data", wr_data, 32'h0);
      check("rst_cp_ctrl", cp_ctrl, 32'h0);
      reset = 1'b0;

      // MCR CRn=1 from phys 3, then MRC CRn=1 to phys 7
      core_regs[3] = 32'h0000_1005;
      core_regs[5] = 32'hFFFF_FFFF;
      apply(mk(1'b0, 4'd1, 4'd15, 1'b1), 6'd3, 32'h13);
      check("tp_cp_ctrl", cp_ctrl, 32'h0000_1005);
      apply(mk(1'b1, 4'd1, 4'd15, 1'b1), 6'd7, 32'h13);
      check("tp_core_r7", core_regs[7], 32'h0000_1005);
      // CP_ID reads, and writes to CRn=0 are dropped
      apply(mk(1'b1, 4'd0, 4'd15, 1'b1), 6'd4, 32'h13);
      apply(mk(1'b0, 4'd0, 4'd15, 1'b1), 6'd5, 32'h13);
      apply(mk(1'b1, 4'd0, 4'd15, 1'b1), 6'd8, 32'h13);
      check("tp_cpid_kept", core_regs[8], 32'h4100_0000);
      // Foreign CP and non-transfer words are ignored
      apply(mk(1'b0, 4'd1, 4'd14, 1'b1), 6'd5, 32'h13);
      apply(mk(1'b0, 4'd1, 4'd15, 1'b0), 6'd5, 32'h13);
      apply(mk(1'b1, 4'd1, 4'd15, 1'b1), 6'd9, 32'h13);
      // MRC to PC
      apply(mk(1'b1, 4'd1, 4'd15, 1'b1), 6'd15, 32'h13);

      // Reset during MCR_CAP
      @(negedge clk);
      dav  = 1'b1;
      word = mk(1'b0, 4'd1, 4'd15, 1'b1);
      creg = 6'd3;
      core_regs[3] = 32'hA5A5_0001;
      @(posedge clk);
      @(negedge clk);
      dav = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midop_rst_cp_ctrl", cp_ctrl, 32'h0);
      check("midop_rst_done", {31'h0, done}, 32'h1);
      check("midop_rst_reg_en", {31'h0, reg_en}, 32'h0);
      reset = 1'b0;
      for (int i = 1; i < 16; i++) cp_model[i] = 32'h0;
      fault_exp = 1'b0;
      @(negedge clk);
      check("midop_no_late_update", cp_ctrl, 32'h0);
      apply(mk(1'b1, 4'd1, 4'd15, 1'b1), 6'd10, 32'h13);

`ifdef ZAP_CP_PRIV_CHECK_EN
      core_regs[3] = 32'h0000_0005;
      apply(mk(1'b0, 4'd1, 4'd15, 1'b1), 6'd3, 32'h10);
      check("usr_cp_ctrl", cp_ctrl, 32'h0);
      apply(mk(1'b1, 4'd0, 4'd15, 1'b1), 6'd11, 32'h10);
      check("usr_mrc_zero", core_regs[11], 32'h0);
      apply(mk(1'b0, 4'd3, 4'd15, 1'b1), 6'd3, 32'h13);
`endif

      // Randomized transactions
      for (int n = 0; n < 60; n++) begin
         logic [3:0]    cp;
         logic          b4;
         logic [IW-1:0] r;
         logic [31:0]   m;
         cp = ($urandom_range(0, 3) != 0) ? 4'd15 : 4'($urandom_range(0, 15));
         b4 = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 7) == 0) ? 6'd15 : 6'($urandom_range(0, 63));
         m  = ($urandom_range(0, 3) == 0) ? 32'h10 : 32'h13;
         apply(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), cp, b4), r, m);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/zap_cp15_responder.md
Name: zap_cp15_responder

Overview:
- Coprocessor-side responder for the core's coprocessor interface: accepts MCR/MRC words the core offers, moves data between the core register file and a 16x32 CP register bank, then signals completion.
- Sits outside zap_top. Drives the core's i_copro_done and i_copro_reg_* inputs, and consumes o_copro_dav, o_copro_word, o_copro_mode, o_copro_reg and o_copro_reg_rd_data.

Parameters:
- PHY_REGS, 64, number of core physical registers; index width is $clog2(PHY_REGS).
- CP_NUM, 15, coprocessor number this block answers to (word bits [11:8]).
- CP_ID, 32'h4100_0000, read-only value of CP register 0.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_copro_dav  in  1  core offers a coprocessor word.
- i_copro_word  in  32  instruction word.
- i_copro_mode  in  32  core CPSR at issue.
- i_copro_reg  in  $clog2(PHY_REGS)  physical index of Rd, pre-banked by the core.
- o_copro_done  out  1  responder idle/complete.
- o_copro_reg_en  out  1  core register write strobe.
- o_copro_reg_wr_index  out  $clog2(PHY_REGS)  write index.
- o_copro_reg_rd_index  out  $clog2(PHY_REGS)  read index.
- o_copro_reg_wr_data  out  32  write data.
- i_copro_reg_rd_data  in  32  core register read data; registered, valid one cycle after rd_index.
- o_cp_ctrl  out  32  CP register 1, for system use (MMU/cache enables).

Behaviour:
- Interface: clock i_clk; reset i_reset is synchronous and active-high.
- Reset state: IDLE, o_copro_done=1, reg_en=0, indices=0, wr_data=0. CP regs 1..15 = 0; reg 0 = CP_ID.
- Decode of the latched word:
  - L = [20] (1 = MRC).
  - CRn = [19:16], cp = [11:8], bit4 = [4].
  - Register transfer needs bit4=1 and cp=CP_NUM; anything else is IGNORED (CDP, LDC/STC, foreign CP).
- Handshake:
  - Accept when i_copro_dav=1 in IDLE: latch word, mode and reg.
  - o_copro_done=0 from the next cycle until the op ends; o_copro_done=1 again in the cycle IDLE is re-entered.
  - The core holds dav until it samples done=1 after acceptance. dav seen high on the first IDLE cycle after completion is a new request, so the core must drop dav in that cycle.
- States:
  - IDLE -> (dav) MCR_RD | MRC_WR | BUSY.
  - MCR_RD: rd_index = latched reg -> MCR_CAP.
  - MCR_CAP: CP[CRn] <= i_copro_reg_rd_data, unless CRn=0 (dropped) -> IDLE. Latency accept-to-done = 3 cycles.
  - MRC_WR: reg_en=1 for exactly one cycle, wr_index = latched reg, wr_data = CP[CRn] -> IDLE. Latency 2 cycles.
  - BUSY (ignored word): one cycle, no side effects -> IDLE. Latency 2 cycles.
- MRC with latched reg = 15 (PC): write suppressed, reg_en stays 0, otherwise same timing.
- CP[CRn] read in MRC_WR reflects any MCR completed earlier; no bypass is needed because ops are serialized.
- dav dropping mid-op: ignored; the op completes.
- Reset mid-op: abort immediately; no register write and no CP update that cycle; all state returns to reset values.
- o_cp_ctrl = CP[1] registered, updated the cycle after MCR_CAP writes CRn=1.

Optional Feature:
- Macro: ZAP_CP_PRIV_CHECK_EN.
- Defined: if latched mode[4:0] = 5'b10000 (USR):
  - MCR updates no CP register.
  - MRC writes 32'h0 to Rd.
  - Timing is unchanged.
  - A sticky o_cp_priv_fault output (1 bit, reset 0) sets; it clears only on reset.
- Undefined: no mode check, and no o_cp_priv_fault port.

Decomposition:
- Shared header zap_cp_defines.vh holds:
  - state encodings (IDLE, MCR_RD, MCR_CAP, MRC_WR, BUSY);
  - word field bit positions;
  - the USR mode constant.
- One sub-module zap_cp_regbank: 16x32 bank with one read and one write port, CP_ID hardwired at index 0 with writes to 0 dropped, and the o_cp_ctrl tap.

Test Plan:
- MCR p15,CRn=1 from Rd phys 3 holding 32'h0000_1005: rd_index=3 on cycle 1; done=1 on cycle 3; o_cp_ctrl=32'h0000_1005 on cycle 4.
- Then MRC p15,CRn=1 to phys 7: reg_en=1, wr_index=7, wr_data=32'h0000_1005 on exactly one cycle; done=1 on cycle 2.
- MRC CRn=0 to phys 4: wr_data=32'h4100_0000. MCR to CRn=0 with 32'hFFFF_FFFF, then MRC: still 32'h4100_0000.
- Word with cp=14, or bit4=0: done low exactly one cycle; reg_en never asserts; CP bank unchanged.
- Reset asserted during MCR_CAP: o_cp_ctrl=0, done=1, reg_en=0 next cycle; no update lands.
- ZAP_CP_PRIV_CHECK_EN with mode 5'b10000: MCR CRn=1 of 32'h5 leaves o_cp_ctrl=0; MRC writes 0; o_cp_priv_fault=1 and stays 1.
